// File: rtl/sram_bist_ctrl.sv
// rtl/sram_bist_ctrl.sv - March C- BIST controller for a dual-port SRAM, port A then port B.
// Optional first-failure capture (FAIL_ADDR/FAIL_ELEM/FAIL_PORT) under `SRAM_BIST_DIAG_EN.
module sram_bist_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              FAIL,
    output logic              A_BIST_EN,
    output logic              A_BIST_MEN,
    output logic              A_BIST_WEN,
    output logic              A_BIST_REN,
    output logic [ADDR_W-1:0] A_BIST_ADDR,
    output logic [DATA_W-1:0] A_BIST_DIN,
    output logic [DATA_W-1:0] A_BIST_BM,
    input  logic [DATA_W-1:0] A_DOUT,
    output logic              B_BIST_EN,
    output logic              B_BIST_MEN,
    output logic              B_BIST_WEN,
    output logic              B_BIST_REN,
    output logic [ADDR_W-1:0] B_BIST_ADDR,
    output logic [DATA_W-1:0] B_BIST_DIN,
    output logic [DATA_W-1:0] B_BIST_BM,
    input  logic [DATA_W-1:0] B_DOUT
`ifdef SRAM_BIST_DIAG_EN
    ,
    output logic [ADDR_W-1:0] FAIL_ADDR,
    output logic [2:0]        FAIL_ELEM,
    output logic              FAIL_PORT
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic              pass_q, pass_d;
    logic [2:0]        elem_q, elem_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cmp_vld_q, cmp_vld_d;
    logic              cmp_exp_q, cmp_exp_d;
    logic              cmp_port_q, cmp_port_d;
    logic              fail_q, fail_d;

    logic start_ok, run, is_down, two_op, is_wr, wr_one, rd_one, last_addr, nxt_down;
    logic miscompare;
    logic act_a, act_b;
    logic [DATA_W-1:0] rd_data;

    always_comb begin
        run       = (state_q == ST_RUN);
        start_ok  = START && ((state_q == ST_IDLE) || (state_q == ST_FINISH));
        is_down   = (elem_q == 3'd3) || (elem_q == 3'd4);
        two_op    = (elem_q != 3'd0) && (elem_q != 3'd5);
        is_wr     = (elem_q == 3'd0) || op_q;
        wr_one    = (elem_q == 3'd1) || (elem_q == 3'd3);
        rd_one    = (elem_q == 3'd2) || (elem_q == 3'd4);
        last_addr = is_down ? (addr_q == '0) : (addr_q == '1);
        nxt_down  = (elem_q == 3'd2) || (elem_q == 3'd3);
    end

    // Sequencer: op within address, then address, then element, then pass.
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        elem_d  = elem_q;
        op_d    = op_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (start_ok) begin
                    state_d = ST_RUN;
                    pass_d  = 1'b0;
                    elem_d  = 3'd0;
                    op_d    = 1'b0;
                    addr_d  = '0;
                end
            end
            ST_RUN: begin
                if (two_op && !op_q) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (last_addr) begin
                        if (elem_q == 3'd5) begin
                            elem_d = 3'd0;
                            addr_d = '0;
                            if (pass_q) state_d = ST_DRAIN;
                            else        pass_d  = 1'b1;
                        end else begin
                            elem_d = elem_q + 3'd1;
                            addr_d = nxt_down ? '1 : '0;
                        end
                    end else begin
                        addr_d = is_down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
                    end
                end
            end
            ST_DRAIN: state_d = ST_FINISH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Read data returns one cycle after REN, so expectation rides one stage behind.
    always_comb begin
        cmp_vld_d  = run && !is_wr;
        cmp_exp_d  = rd_one;
        cmp_port_d = pass_q;
        rd_data    = cmp_port_q ? B_DOUT : A_DOUT;
        miscompare = cmp_vld_q && (rd_data != {DATA_W{cmp_exp_q}});
        fail_d     = start_ok ? 1'b0 : (fail_q || miscompare);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            pass_q     <= 1'b0;
            elem_q     <= 3'd0;
            op_q       <= 1'b0;
            addr_q     <= '0;
            cmp_vld_q  <= 1'b0;
            cmp_exp_q  <= 1'b0;
            cmp_port_q <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pass_q     <= pass_d;
            elem_q     <= elem_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            cmp_vld_q  <= cmp_vld_d;
            cmp_exp_q  <= cmp_exp_d;
            cmp_port_q <= cmp_port_d;
            fail_q     <= fail_d;
        end
    end

`ifdef SRAM_BIST_DIAG_EN
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d, fail_addr_q, fail_addr_d;
    logic [2:0]        cmp_elem_q, cmp_elem_d, fail_elem_q, fail_elem_d;
    logic              fail_port_q, fail_port_d;
    logic              first_fail;

    always_comb begin
        cmp_addr_d  = addr_q;
        cmp_elem_d  = elem_q;
        first_fail  = miscompare && !fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        fail_port_d = fail_port_q;
        if (start_ok) begin
            fail_addr_d = '0;
            fail_elem_d = 3'd0;
            fail_port_d = 1'b0;
        end else if (first_fail) begin
            fail_addr_d = cmp_addr_q;
            fail_elem_d = cmp_elem_q;
            fail_port_d = cmp_port_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cmp_addr_q  <= '0;
            cmp_elem_q  <= 3'd0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
            fail_port_q <= 1'b0;
        end else begin
            cmp_addr_q  <= cmp_addr_d;
            cmp_elem_q  <= cmp_elem_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_port_q <= fail_port_d;
        end
    end

    assign FAIL_ADDR = fail_addr_q;
    assign FAIL_ELEM = fail_elem_q;
    assign FAIL_PORT = fail_port_q;
`endif

    always_comb begin
        act_a       = run && !pass_q;
        act_b       = run && pass_q;
        BUSY        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        DONE        = (state_q == ST_FINISH);
        FAIL        = fail_q;
        A_BIST_EN   = act_a;
        A_BIST_MEN  = act_a;
        A_BIST_WEN  = act_a && is_wr;
        A_BIST_REN  = act_a && !is_wr;
        A_BIST_ADDR = act_a ? addr_q : '0;
        A_BIST_DIN  = (act_a && is_wr && wr_one) ? '1 : '0;
        A_BIST_BM   = (act_a && is_wr) ? '1 : '0;
        B_BIST_EN   = act_b;
        B_BIST_MEN  = act_b;
        B_BIST_WEN  = act_b && is_wr;
        B_BIST_REN  = act_b && !is_wr;
        B_BIST_ADDR = act_b ? addr_q : '0;
        B_BIST_DIN  = (act_b && is_wr && wr_one) ? '1 : '0;
        B_BIST_BM   = (act_b && is_wr) ? '1 : '0;
    end

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// tb/tb_sram_bist_ctrl.sv - scoreboard bench for sram_bist_ctrl with a dual-port SRAM model and stuck-at faults.
module tb_sram_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        busy, done, fail;
    logic        a_en, a_men, a_wen, a_ren, b_en, b_men, b_wen, b_ren;
    logic [7:0]  a_addr, b_addr;
    logic [31:0] a_din, a_bm, a_dout, b_din, b_bm, b_dout;
`ifdef SRAM_BIST_DIAG_EN
    logic [7:0]  fail_addr;
    logic [2:0]  fail_elem;
    logic        fail_port;
`endif

    always #5 clk = ~clk;

    sram_bist_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
        .CLK(clk), .RST(rst), .START(start), .BUSY(busy), .DONE(done), .FAIL(fail),
        .A_BIST_EN(a_en), .A_BIST_MEN(a_men), .A_BIST_WEN(a_wen), .A_BIST_REN(a_ren),
        .A_BIST_ADDR(a_addr), .A_BIST_DIN(a_din), .A_BIST_BM(a_bm), .A_DOUT(a_dout),
        .B_BIST_EN(b_en), .B_BIST_MEN(b_men), .B_BIST_WEN(b_wen), .B_BIST_REN(b_ren),
        .B_BIST_ADDR(b_addr), .B_BIST_DIN(b_din), .B_BIST_BM(b_bm), .B_DOUT(b_dout)
`ifdef SRAM_BIST_DIAG_EN
        , .FAIL_ADDR(fail_addr), .FAIL_ELEM(fail_elem), .FAIL_PORT(fail_port)
`endif
    );

    // SRAM model: port A bit 5 of 0x3C stuck at 1, port B bit 0 of 0xFF stuck at 0
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic        fa_on, fb_on;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        a_dout = 32'h0;
        b_dout = 32'h0;
    end

    always @(posedge clk) begin
        if (a_en && a_men && a_wen) mem_a[a_addr] <= (mem_a[a_addr] & ~a_bm) | (a_din & a_bm);
        if (a_en && a_men && a_ren)
            a_dout <= (fa_on && a_addr == 8'h3C) ? (mem_a[a_addr] | 32'h20) : mem_a[a_addr];
        if (b_en && b_men && b_wen) mem_b[b_addr] <= (mem_b[b_addr] & ~b_bm) | (b_din & b_bm);
        if (b_en && b_men && b_ren)
            b_dout <= (fb_on && b_addr == 8'hFF) ? (mem_b[b_addr] & ~32'h1) : mem_b[b_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic       fail;
        int         busy_len;
        int         fail_cyc;
        logic [7:0] faddr;
        logic [2:0] felem;
        logic       fport;
    } exp_t;

    exp_t sb_q[$];

    int   busy_cnt = 0;
    int   first_fail = 0;
    int   viol = 0;
    logic done_prev = 1'b0;

    // Monitor: trace checks by BUSY cycle index, result compare on each DONE rise
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_cnt   = 0;
            first_fail = 0;
            viol       = 0;
        end else begin
            if (busy) begin
                busy_cnt++;
                if (fail && first_fail == 0) first_fail = busy_cnt;
                if (busy_cnt <= 2560 && (b_en || !(a_wen ^ a_ren))) viol++;
                if (busy_cnt > 2560 && busy_cnt <= 5120 && (a_en || !(b_wen ^ b_ren))) viol++;
                if (busy_cnt == 1)
                    check("first_op", {a_wen, a_ren, a_addr, a_din, a_bm[7:0], b_en},
                          {1'b1, 1'b0, 8'h00, 32'h0, 8'hFF, 1'b0});
                if (busy_cnt == 1281)
                    check("e3_start", {a_wen, a_ren, a_addr}, {1'b0, 1'b1, 8'hFF});
                if (busy_cnt == 2560)
                    check("pass0_last", {a_ren, a_addr}, {1'b1, 8'hFF});
                if (busy_cnt == 2561)
                    check("pass1_first", {b_wen, b_ren, b_addr, b_din, a_en}, {1'b1, 1'b0, 8'h00, 32'h0, 1'b0});
                if (busy_cnt == 5121)
                    check("drain_idle_ports", {a_en, b_en, b_men, b_addr}, {1'b0, 1'b0, 1'b0, 8'h00});
            end
            if (done && !done_prev) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_done", 1'b1, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    check("fail_flag", fail, e.fail);
                    check("busy_len", busy_cnt, e.busy_len);
                    check("fail_cycle", first_fail, e.fail_cyc);
                    check("port_protocol_viol", viol, 0);
`ifdef SRAM_BIST_DIAG_EN
                    check("fail_addr", fail_addr, e.faddr);
                    check("fail_elem", fail_elem, e.felem);
                    check("fail_port", fail_port, e.fport);
`endif
                end
                busy_cnt   = 0;
                first_fail = 0;
                viol       = 0;
            end
        end
        done_prev = done;
    end

    task automatic push_exp(input logic f, input int fc, input logic [7:0] fa, input logic [2:0] fe, input logic fp);
        exp_t e;
        e.fail = f; e.busy_len = 5121; e.fail_cyc = fc;
        e.faddr = fa; e.felem = fe; e.fport = fp;
        sb_q.push_back(e);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("run_done_timeout", done, 1'b1);
    endtask

    task automatic wait_busy_cnt(input int target);
        int n = 0;
        while (busy_cnt != target && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("busy_cnt_reach", busy_cnt, target);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {busy, done, fail, a_en, a_men, a_wen, a_ren, a_addr, a_din, a_bm,
                     b_en, b_men, b_wen, b_ren, b_addr, b_din, b_bm}, '0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; fa_on = 1'b0; fb_on = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset_outputs");

        // fault-free run
        push_exp(1'b0, 0, 8'h00, 3'd0, 1'b0);
        pulse_start();
        wait_done();

        // port A 0x3C bit5 SA1: first caught by E1 r0, read at busy 377, FAIL visible at 379
        fa_on = 1'b1;
        push_exp(1'b1, 379, 8'h3C, 3'd1, 1'b0);
        pulse_start();
        wait_done();
        fa_on = 1'b0;

        // port B 0xFF bit0 SA0: first caught by E2 r1, read at busy 3839, FAIL visible at 3841
        fb_on = 1'b1;
        push_exp(1'b1, 3841, 8'hFF, 3'd2, 1'b1);
        pulse_start();
        wait_done();
        fb_on = 1'b0;

        // restart from FINISH after a failing run; START mid-run is ignored
        push_exp(1'b0, 0, 8'h00, 3'd0, 1'b0);
        pulse_start();
        @(negedge clk);
        check("restart_clear", {done, fail, busy}, {1'b0, 1'b0, 1'b1});
        wait_busy_cnt(100);
        pulse_start();
        wait_done();

        // abort with RST mid-run
        pulse_start();
        wait_busy_cnt(1000);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("abort_outputs");
        repeat (3) @(negedge clk);
        check("abort_stays_idle", {busy, a_en, b_en}, 3'b000);

        // controller accepts START from IDLE after abort
        push_exp(1'b0, 0, 8'h00, 3'd0, 1'b0);
        pulse_start();
        wait_done();

        repeat (2) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
